// File: rtl/xm_stage_pkg.sv
// rtl/xm_stage_pkg.sv - shared constants, types and decode helpers for the X/M pipeline stage
package xm_stage_pkg;

    localparam logic [4:0]  OP_ALU      = 5'b00000;
    localparam logic [4:0]  OP_ADDI     = 5'b00101;
    localparam logic [4:0]  ALU_ADD     = 5'b00000;
    localparam logic [4:0]  ALU_SUB     = 5'b00001;
    localparam logic [4:0]  ALU_MUL     = 5'b00110;
    localparam logic [4:0]  ALU_DIV     = 5'b00111;

    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] RS_ADD_OVF  = 32'd1;
    localparam logic [31:0] RS_ADDI_OVF = 32'd2;
    localparam logic [31:0] RS_SUB_OVF  = 32'd3;
    localparam logic [31:0] RS_MUL_EXC  = 32'd4;
    localparam logic [31:0] RS_DIV_EXC  = 32'd5;

    localparam logic [5:0]  MD_TIMEOUT  = 6'd63;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
    typedef enum logic [1:0] {SEL_BUBBLE, SEL_ALU, SEL_MD} xm_sel_e;

    function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] aluop);
        return (opcode == OP_ALU) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    endfunction

    // Zero means the instruction has no overflow exception to report.
    function automatic logic [31:0] ovf_code(input logic [4:0] opcode, input logic [4:0] aluop);
        if (opcode == OP_ADDI)
            return RS_ADDI_OVF;
        if ((opcode == OP_ALU) && (aluop == ALU_ADD))
            return RS_ADD_OVF;
        if ((opcode == OP_ALU) && (aluop == ALU_SUB))
            return RS_SUB_OVF;
        return 32'd0;
    endfunction

endpackage

// File: rtl/register32.sv
// rtl/register32.sv - 32-bit register cell with write enable and asynchronous clear
module register32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= 32'd0;
        else if (write_enable)
            q <= d;
    end

endmodule

// File: rtl/xm_md_ctrl.sv
// rtl/xm_md_ctrl.sv - multdiv handshake FSM with timeout; chooses what the XM latch captures
module xm_md_ctrl
    import xm_stage_pkg::*;
(
    input  logic    clock,
    input  logic    XM_reset,
    input  logic    is_md,
    input  logic    is_div,
    input  logic    flush,
    input  logic    md_ready,
    input  logic    md_exception,
    output logic    md_start,
    output logic    md_is_div,
    output logic    stall,
    output logic    md_fault,
    output xm_sel_e sel
);

    md_state_e  state, state_nx;
    logic [5:0] cnt, cnt_nx;

    always_ff @(posedge clock or posedge XM_reset) begin
        if (XM_reset) begin
            state <= MD_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign md_is_div = is_div;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        md_start = 1'b0;
        stall    = 1'b0;
        md_fault = 1'b0;
        sel      = SEL_ALU;
        if (XM_reset) begin
            // Keep the front of the pipe free while reset is held.
            sel = SEL_BUBBLE;
        end else if (flush) begin
            sel      = SEL_BUBBLE;
            state_nx = MD_IDLE;
            cnt_nx   = 6'd0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    cnt_nx = 6'd0;
                    if (is_md) begin
                        md_start = 1'b1;
                        stall    = 1'b1;
                        sel      = SEL_BUBBLE;
                        state_nx = MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (md_ready || (cnt == MD_TIMEOUT)) begin
                        // A timeout completes the op as if the unit raised an exception.
                        sel      = SEL_MD;
                        md_fault = md_ready ? md_exception : 1'b1;
                        state_nx = MD_IDLE;
                        cnt_nx   = 6'd0;
                    end else begin
                        stall  = 1'b1;
                        sel    = SEL_BUBBLE;
                        cnt_nx = cnt + 6'd1;
                    end
                end
                default: state_nx = MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/xm_stage.sv
// rtl/xm_stage.sv - X/M pipeline register with multdiv sequencing and exception rewrite
module xm_stage
    import xm_stage_pkg::*;
(
    input  logic        clock,
    input  logic        XM_reset,
    input  logic [4:0]  opcode_x,
    input  logic [4:0]  aluop_x,
    input  logic [4:0]  rd_x,
    input  logic [31:0] alu_result,
    input  logic        alu_ovf,
    input  logic [31:0] regB_x,
    input  logic [31:0] pc_x,
    input  logic        flush,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        md_start,
    output logic        md_is_div,
    output logic        stall,
    output logic [4:0]  xm_opcode,
    output logic [4:0]  xm_rd,
    output logic [31:0] xm_O,
    output logic [31:0] xm_B,
    output logic [31:0] xm_pc
);

    xm_sel_e     sel;
    logic        md_fault;
    logic        is_div;
    logic [4:0]  opcode_d, rd_d;
    logic [31:0] o_d, b_d, pc_d, ovf_rs;

    assign is_div = (aluop_x == ALU_DIV);

    xm_md_ctrl u_md_ctrl (
        .clock        (clock),
        .XM_reset     (XM_reset),
        .is_md        (is_md_op(opcode_x, aluop_x)),
        .is_div       (is_div),
        .flush        (flush),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .stall        (stall),
        .md_fault     (md_fault),
        .sel          (sel)
    );

    always_comb begin
        opcode_d = 5'd0;
        rd_d     = 5'd0;
        o_d      = 32'd0;
        b_d      = 32'd0;
        pc_d     = 32'd0;
        ovf_rs   = ovf_code(opcode_x, aluop_x);
        unique case (sel)
            SEL_ALU: begin
                opcode_d = opcode_x;
                rd_d     = rd_x;
                o_d      = alu_result;
                b_d      = regB_x;
                pc_d     = pc_x;
                if (alu_ovf && (ovf_rs != 32'd0)) begin
                    rd_d = RSTATUS_REG;
                    o_d  = ovf_rs;
                end
            end
            SEL_MD: begin
                opcode_d = opcode_x;
                rd_d     = rd_x;
                o_d      = md_result;
                b_d      = regB_x;
                pc_d     = pc_x;
                if (md_fault) begin
                    rd_d = RSTATUS_REG;
                    o_d  = is_div ? RS_DIV_EXC : RS_MUL_EXC;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge XM_reset) begin
        if (XM_reset) begin
            xm_opcode <= 5'd0;
            xm_rd     <= 5'd0;
        end else begin
            xm_opcode <= opcode_d;
            xm_rd     <= rd_d;
        end
    end

    register32 u_reg_o  (.clock(clock), .reset(XM_reset), .write_enable(1'b1), .d(o_d),  .q(xm_O));
    register32 u_reg_b  (.clock(clock), .reset(XM_reset), .write_enable(1'b1), .d(b_d),  .q(xm_B));
    register32 u_reg_pc (.clock(clock), .reset(XM_reset), .write_enable(1'b1), .d(pc_d), .q(xm_pc));

endmodule

// File: tb/tb_xm_stage.sv
// tb/tb_xm_stage.sv - self-checking bench: vector table, directed multdiv sequences, random transactions
`timescale 1ns/1ps
module tb_xm_stage;

    logic        clock = 1'b0;
    logic        XM_reset;
    logic [4:0]  opcode_x, aluop_x, rd_x;
    logic [31:0] alu_result, regB_x, pc_x, md_result;
    logic        alu_ovf, flush, md_ready, md_exception;
    logic        md_start, md_is_div, stall;
    logic [4:0]  xm_opcode, xm_rd;
    logic [31:0] xm_O, xm_B, xm_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    xm_stage dut (
        .clock        (clock),
        .XM_reset     (XM_reset),
        .opcode_x     (opcode_x),
        .aluop_x      (aluop_x),
        .rd_x         (rd_x),
        .alu_result   (alu_result),
        .alu_ovf      (alu_ovf),
        .regB_x       (regB_x),
        .pc_x         (pc_x),
        .flush        (flush),
        .md_ready     (md_ready),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .stall        (stall),
        .xm_opcode    (xm_opcode),
        .xm_rd        (xm_rd),
        .xm_O         (xm_O),
        .xm_B         (xm_B),
        .xm_pc        (xm_pc)
    );

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  aluop;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ovf;
        logic [31:0] b;
        logic [31:0] pc;
        logic [4:0]  e_rd;
        logic [31:0] e_o;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_xm(input string tag, input logic [4:0] op, input logic [4:0] rd,
                          input logic [31:0] o, input logic [31:0] b, input logic [31:0] pc);
        chk({tag, ".xm_opcode"}, {27'd0, xm_opcode}, {27'd0, op});
        chk({tag, ".xm_rd"}, {27'd0, xm_rd}, {27'd0, rd});
        chk({tag, ".xm_O"}, xm_O, o);
        chk({tag, ".xm_B"}, xm_B, b);
        chk({tag, ".xm_pc"}, xm_pc, pc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_x(input logic [4:0] op, input logic [4:0] aluop, input logic [4:0] rd,
                           input logic [31:0] res, input logic ovf, input logic [31:0] b,
                           input logic [31:0] pc);
        opcode_x   = op;
        aluop_x    = aluop;
        rd_x       = rd;
        alu_result = res;
        alu_ovf    = ovf;
        regB_x     = b;
        pc_x       = pc;
    endtask

    // Non-multdiv instruction: one-cycle latency, overflow on add/addi/sub goes to rstatus.
    task automatic alu_txn(input logic [4:0] op, input logic [4:0] aluop, input logic [4:0] rd,
                           input logic [31:0] res, input logic ovf, input logic [31:0] b,
                           input logic [31:0] pc, input logic fl, input string tag);
        logic [4:0]  e_rd;
        logic [31:0] e_o, code;
        code = 32'd0;
        if (op == 5'd5)                        code = 32'd1 + 32'd1;
        else if (op == 5'd0 && aluop == 5'd0)  code = 32'd1;
        else if (op == 5'd0 && aluop == 5'd1)  code = 32'd3;
        e_rd = (ovf && code != 0) ? 5'd30 : rd;
        e_o  = (ovf && code != 0) ? code : res;
        drive_x(op, aluop, rd, res, ovf, b, pc);
        flush = fl;
        #1;
        chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
        chk({tag, ".md_start"}, {31'd0, md_start}, 32'd0);
        tick();
        if (fl) chk_xm(tag, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        else    chk_xm(tag, op, e_rd, e_o, b, pc);
        flush = 1'b0;
    endtask

    // Multdiv op held in X. md_ready rises at BUSY cycle index lat (0-based); the op
    // is forced to complete as an exception at BUSY index 63. flush_at counts cycles
    // from the start cycle (0 = the IDLE cycle); -1 means never.
    task automatic md_txn(input logic is_div, input int lat, input logic exc, input int flush_at,
                          input logic [4:0] rd, input logic [31:0] res, input logic [31:0] b,
                          input logic [31:0] pc, input string tag, output int stalls,
                          output int bubbles);
        logic done, fault;
        int   i;
        stalls  = 0;
        bubbles = 0;
        done    = 1'b0;
        for (int k = 0; k < 80 && !done; k++) begin
            i = k - 1;
            drive_x(5'd0, is_div ? 5'd7 : 5'd6, rd, $urandom, 1'($urandom_range(0, 1)), b, pc);
            flush        = (k == flush_at);
            md_ready     = (k > 0) && (i == lat);
            md_exception = md_ready ? exc : 1'($urandom_range(0, 1));
            md_result    = md_ready ? res : $urandom;
            #1;
            if (flush) begin
                chk({tag, ".flush.stall"}, {31'd0, stall}, 32'd0);
                chk({tag, ".flush.md_start"}, {31'd0, md_start}, 32'd0);
                tick();
                chk_xm({tag, ".flush"}, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
                done = 1'b1;
            end else if (k == 0) begin
                chk({tag, ".md_start"}, {31'd0, md_start}, 32'd1);
                chk({tag, ".md_is_div"}, {31'd0, md_is_div}, {31'd0, is_div});
                chk({tag, ".start.stall"}, {31'd0, stall}, 32'd1);
                stalls++;
                tick();
                chk_xm({tag, ".bubble"}, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
                bubbles++;
            end else if (md_ready || i == 63) begin
                fault = md_ready ? exc : 1'b1;
                chk({tag, ".done.stall"}, {31'd0, stall}, 32'd0);
                chk({tag, ".done.md_start"}, {31'd0, md_start}, 32'd0);
                tick();
                chk_xm({tag, ".done"}, 5'd0, fault ? 5'd30 : rd,
                       fault ? (is_div ? 32'd5 : 32'd4) : res, b, pc);
                done = 1'b1;
            end else begin
                chk({tag, ".busy.stall"}, {31'd0, stall}, 32'd1);
                chk({tag, ".busy.md_start"}, {31'd0, md_start}, 32'd0);
                stalls++;
                tick();
                chk_xm({tag, ".bubble"}, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
                bubbles++;
            end
        end
        md_ready     = 1'b0;
        md_exception = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        int   s, bb, kind, lat, fa;
        logic [4:0] op;

        vt[0] = '{5'd0, 5'd0, 5'd3,  32'h0000_0007, 1'b0, 32'h11, 32'h100, 5'd3,  32'h0000_0007};
        vt[1] = '{5'd0, 5'd0, 5'd4,  32'h8000_0000, 1'b1, 32'h22, 32'h101, 5'd30, 32'd1};
        vt[2] = '{5'd5, 5'd31, 5'd9, 32'h7fff_ffff, 1'b1, 32'h33, 32'h102, 5'd30, 32'd2};
        vt[3] = '{5'd0, 5'd1, 5'd12, 32'h8000_0001, 1'b1, 32'h44, 32'h103, 5'd30, 32'd3};
        vt[4] = '{5'd0, 5'd1, 5'd12, 32'hffff_fffe, 1'b0, 32'h55, 32'h104, 5'd12, 32'hffff_fffe};
        vt[5] = '{5'd0, 5'd2, 5'd7,  32'h0000_00f0, 1'b1, 32'h66, 32'h105, 5'd7,  32'h0000_00f0};
        vt[6] = '{5'd8, 5'd0, 5'd8,  32'h0000_0044, 1'b1, 32'h77, 32'h106, 5'd8,  32'h0000_0044};
        vt[7] = '{5'd5, 5'd0, 5'd31, 32'h0000_1234, 1'b0, 32'h88, 32'h107, 5'd31, 32'h0000_1234};

        XM_reset     = 1'b1;
        flush        = 1'b0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'd0;
        drive_x(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        #12;
        chk("reset.stall", {31'd0, stall}, 32'd0);
        chk("reset.md_start", {31'd0, md_start}, 32'd0);
        chk_xm("reset", 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clock);
        XM_reset = 1'b0;
        tick();

        for (int n = 0; n < 8; n++) begin
            drive_x(vt[n].op, vt[n].aluop, vt[n].rd, vt[n].res, vt[n].ovf, vt[n].b, vt[n].pc);
            #1;
            chk($sformatf("vec%0d.stall", n), {31'd0, stall}, 32'd0);
            tick();
            chk_xm($sformatf("vec%0d", n), vt[n].op, vt[n].e_rd, vt[n].e_o, vt[n].b, vt[n].pc);
        end

        md_txn(1'b0, 4, 1'b0, -1, 5'd5, 32'h30, 32'h5a, 32'h200, "mul", s, bb);
        chk("mul.stall_cycles", s, 32'd5);
        chk("mul.bubbles", bb, 32'd5);
        alu_txn(5'd0, 5'd0, 5'd2, 32'h99, 1'b0, 32'h1, 32'h201, 1'b0, "after_mul");

        md_txn(1'b1, 2, 1'b1, -1, 5'd6, 32'hdead_beef, 32'h5b, 32'h210, "div_exc", s, bb);

        md_txn(1'b1, 3, 1'b0, 2, 5'd7, 32'h1111, 32'h5c, 32'h220, "div_flush", s, bb);
        md_ready  = 1'b1;
        md_result = 32'hbad0_bad0;
        alu_txn(5'd0, 5'd0, 5'd6, 32'h55, 1'b0, 32'h2, 32'h221, 1'b0, "late_ready");
        md_ready  = 1'b0;

        md_txn(1'b0, 2, 1'b0, 3, 5'd8, 32'h2222, 32'h5d, 32'h230, "flush_wins", s, bb);
        md_txn(1'b0, 1, 1'b0, 0, 5'd9, 32'h3333, 32'h5e, 32'h240, "flush_idle", s, bb);
        md_txn(1'b0, 0, 1'b0, -1, 5'd9, 32'h4444, 32'h5e, 32'h241, "restart", s, bb);

        md_txn(1'b0, 500, 1'b0, -1, 5'd10, 32'h5555, 32'h5f, 32'h250, "timeout", s, bb);
        chk("timeout.stall_cycles", s, 32'd64);
        alu_txn(5'd0, 5'd1, 5'd11, 32'h66, 1'b0, 32'h3, 32'h251, 1'b0, "after_timeout");

        // Asynchronous reset landing between edges while BUSY.
        drive_x(5'd0, 5'd6, 5'd12, 32'd0, 1'b0, 32'h60, 32'h260);
        tick();
        tick();
        chk("rst_busy.pre.stall", {31'd0, stall}, 32'd1);
        #2;
        XM_reset = 1'b1;
        #1;
        chk("rst_busy.stall", {31'd0, stall}, 32'd0);
        chk("rst_busy.md_start", {31'd0, md_start}, 32'd0);
        chk_xm("rst_busy", 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        #1;
        XM_reset = 1'b0;
        md_txn(1'b0, 1, 1'b0, -1, 5'd12, 32'h7777, 32'h60, 32'h260, "post_rst", s, bb);

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                if ($urandom_range(0, 2) == 0) op = 5'd5;
                else if ($urandom_range(0, 1) == 0) op = 5'd0;
                else op = 5'($urandom_range(1, 31));
                alu_txn(op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 31)), $urandom,
                        1'($urandom_range(0, 1)), $urandom, $urandom,
                        1'($urandom_range(0, 7) == 0), $sformatf("rnd%0d", t));
            end else begin
                lat = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 6));
                fa  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
                md_txn(1'($urandom_range(0, 1)), lat, 1'($urandom_range(0, 1)), fa,
                       5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                       $sformatf("rnd%0d", t), s, bb);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
